// File: rtl/cbus_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : cbus_axi_bridge
//  Description : Single-outstanding cbus (creq/cresp) to AXI3 master bridge,
//                INCR/FIXED bursts of 1..16 beats, 32-bit data.
//  Revision    : 1.0 - initial release
// ============================================================================

package cbus_axi_bridge_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_axi_bridge
    import cbus_axi_bridge_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int AXI_ID = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  cbus_req_t       creq,
    output cbus_resp_t      cresp,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [3:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [3:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready,
    output logic            bus_err
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_AR   = 3'd1;
    localparam logic [2:0] c_ST_R    = 3'd2;
    localparam logic [2:0] c_ST_AW   = 3'd3;
    localparam logic [2:0] c_ST_W    = 3'd4;
    localparam logic [2:0] c_ST_B    = 3'd5;

    logic [2:0]  r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [3:0]  r_len;
    logic [1:0]  r_burst;
    logic [3:0]  r_beat_cnt;

    logic        w_r_beat;
    logic        w_w_beat;
    logic        w_b_beat;
    logic        w_final_w;

    // Response IDs are never compared; only one transaction is ever in flight.
    logic        w_unused_ids;
    assign w_unused_ids = ^{rid, bid};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_addr     <= '0;
            r_size     <= '0;
            r_len      <= '0;
            r_burst    <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (creq.valid) begin
                        r_addr  <= creq.addr;
                        r_size  <= creq.size;
                        r_len   <= creq.len;
                        r_burst <= creq.burst;
                        r_state <= creq.is_write ? c_ST_AW : c_ST_AR;
                    end
                end
                c_ST_AR: begin
                    if (arready) begin
                        r_beat_cnt <= '0;
                        r_state    <= c_ST_R;
                    end
                end
                c_ST_R: begin
                    if (w_r_beat && rlast) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_AW: begin
                    if (awready) begin
                        r_beat_cnt <= '0;
                        r_state    <= c_ST_W;
                    end
                end
                c_ST_W: begin
                    if (w_w_beat) begin
                        if (w_final_w) begin
                            r_state <= c_ST_B;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 4'd1;
                        end
                    end
                end
                c_ST_B: begin
                    if (bvalid) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Handshake strobes are decoded from state so stray rvalid/bvalid are ignored.
    always_comb begin
        arvalid   = (r_state == c_ST_AR);
        awvalid   = (r_state == c_ST_AW);
        wvalid    = (r_state == c_ST_W);
        rready    = (r_state == c_ST_R);
        bready    = (r_state == c_ST_B);

        w_r_beat  = rready && rvalid;
        w_w_beat  = wvalid && wready;
        w_b_beat  = bready && bvalid;
        w_final_w = (r_beat_cnt == r_len);

        arid      = ID_W'(AXI_ID);
        araddr    = r_addr;
        arlen     = r_len;
        arsize    = r_size;
        arburst   = r_burst;

        awid      = ID_W'(AXI_ID);
        awaddr    = r_addr;
        awlen     = r_len;
        awsize    = r_size;
        awburst   = r_burst;

        wid       = ID_W'(AXI_ID);
        wdata     = creq.data;
        wstrb     = creq.strobe;
        wlast     = wvalid && w_final_w;

        // The last write beat is acknowledged from the B response, not from W.
        cresp       = '0;
        cresp.ready = w_r_beat || (w_w_beat && !w_final_w) || w_b_beat;
        cresp.last  = (w_r_beat && rlast) || w_b_beat;
        cresp.data  = w_r_beat ? rdata : 32'h0;

        bus_err   = (w_r_beat && (rresp != 2'b00)) || (w_b_beat && (bresp != 2'b00));
    end

endmodule

`default_nettype wire

// File: tb/tb_cbus_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cbus_axi_bridge
//  Description : Scoreboard bench for cbus_axi_bridge with directed and
//                randomized cbus/AXI traffic.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_cbus_axi_bridge;
    import cbus_axi_bridge_pkg::*;

    localparam int ID_W   = 4;
    localparam int AXI_ID = 3;

    logic            clk;
    logic            reset;
    cbus_req_t       creq;
    cbus_resp_t      cresp;
    logic [ID_W-1:0] arid, rid, awid, wid, bid;
    logic [31:0]     araddr, rdata, awaddr, wdata;
    logic [3:0]      arlen, awlen, wstrb;
    logic [2:0]      arsize, awsize;
    logic [1:0]      arburst, awburst, rresp, bresp;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready;
    logic            bvalid, bready, bus_err;

    cbus_axi_bridge #(.ID_W(ID_W), .AXI_ID(AXI_ID)) dut (
        .clk(clk), .reset(reset), .creq(creq), .cresp(cresp),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected traffic: address phases, write beats and cbus acks {last, err, data}.
    logic [44:0] exp_ar_q[$];
    logic [44:0] exp_aw_q[$];
    logic [36:0] exp_w_q[$];
    logic [33:0] exp_c_q[$];

    logic [31:0] bd[16];
    logic [1:0]  br[16];
    logic [3:0]  bs[16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=handshake required=none t=%0t", nm, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (arvalid && arready) begin
            if (exp_ar_q.size() == 0) unexpected("ar_unexpected");
            else check("ar_fields", 64'({arid, araddr, arlen, arsize, arburst}), 64'(exp_ar_q.pop_front()));
        end
        if (awvalid && awready) begin
            if (exp_aw_q.size() == 0) unexpected("aw_unexpected");
            else check("aw_fields", 64'({awid, awaddr, awlen, awsize, awburst}), 64'(exp_aw_q.pop_front()));
        end
        if (wvalid && wready) begin
            if (exp_w_q.size() == 0) unexpected("w_unexpected");
            else check("w_beat", 64'({wid, wdata, wstrb, wlast}), 64'({4'(AXI_ID), exp_w_q.pop_front()}));
        end
        if (cresp.ready) begin
            if (exp_c_q.size() == 0) unexpected("cresp_unexpected");
            else check("cresp_beat", 64'({cresp.last, bus_err, cresp.data}), 64'(exp_c_q.pop_front()));
        end else begin
            check("cresp_quiet", 64'({cresp.last, bus_err, cresp.data}), 64'd0);
        end
    end

    task automatic fill_rand(input bit with_err);
        for (int i = 0; i < 16; i++) begin
            bd[i] = $urandom;
            bs[i] = 4'($urandom);
            br[i] = (with_err && ($urandom_range(7, 0) == 0)) ? 2'($urandom_range(3, 1)) : 2'b00;
        end
    endtask

    task automatic drive_req(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        creq.valid    = 1'b1;
        creq.is_write = wr;
        creq.addr     = addr;
        creq.len      = len;
        creq.size     = size;
        creq.burst    = burst;
        creq.data     = wr ? bd[0] : $urandom;
        creq.strobe   = wr ? bs[0] : 4'($urandom);
    endtask

    // rst_at >= 0 asserts reset while beat rst_at is being presented.
    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int gap_lo, input int gap_hi,
                           input int ar_dly, input bit b2b, input int rst_at);
        int n;
        exp_ar_q.push_back({4'(AXI_ID), addr, len, size, burst});
        for (int i = 0; i <= int'(len); i++) exp_c_q.push_back({(i == int'(len)), (br[i] != 2'b00), bd[i]});
        if (!b2b) tick();
        drive_req(1'b0, addr, len, size, burst);
        n = 0;
        do begin tick(); n++; end while (!arvalid && n < 30);
        check("ar_latency", 64'(n), 64'd1);
        for (int d = 0; d < ar_dly; d++) begin
            rvalid = 1'b1; rlast = 1'b1; rresp = 2'b10; rdata = $urandom;
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        arready = 1'b1; tick(); arready = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            repeat ($urandom_range(gap_hi, gap_lo)) tick();
            rvalid = 1'b1; rdata = bd[i]; rresp = br[i]; rlast = (i == int'(len)); rid = 4'($urandom);
            if (i == rst_at) begin
                #2 reset = 1'b1;
                #1 check("rst_async_out", 64'({arvalid, awvalid, wvalid, rready, bready, cresp.ready, bus_err}), 64'd0);
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; creq.valid = 1'b0;
                exp_c_q.delete();
                tick(); tick();
                reset = 1'b0;
                tick();
                check("rst_after_out", 64'({arvalid, awvalid, wvalid, rready, bready, cresp.ready, bus_err}), 64'd0);
                break;
            end
            tick();
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        end
        creq.valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int aw_dly, input int stall_beat,
                            input int stall_len, input int stall_max, input int b_dly,
                            input logic [1:0] bresp_v, input bit b2b);
        int n;
        exp_aw_q.push_back({4'(AXI_ID), addr, len, size, burst});
        for (int i = 0; i <= int'(len); i++) exp_w_q.push_back({bd[i], bs[i], (i == int'(len))});
        for (int i = 0; i < int'(len); i++) exp_c_q.push_back(34'h0);
        exp_c_q.push_back({1'b1, (bresp_v != 2'b00), 32'h0});
        if (!b2b) tick();
        drive_req(1'b1, addr, len, size, burst);
        n = 0;
        do begin tick(); n++; end while (!awvalid && n < 30);
        check("aw_latency", 64'(n), 64'd1);
        repeat (aw_dly) tick();
        awready = 1'b1; tick(); awready = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            creq.data = bd[i]; creq.strobe = bs[i];
            n = (i == stall_beat) ? stall_len : int'($urandom_range(stall_max, 0));
            for (int s = 0; s < n; s++) begin
                bvalid = 1'b1; bresp = 2'b10;
                tick();
            end
            bvalid = 1'b0; bresp = 2'b00;
            wready = 1'b1; tick(); wready = 1'b0;
        end
        repeat (b_dly) tick();
        bvalid = 1'b1; bresp = bresp_v; bid = 4'($urandom);
        tick();
        bvalid = 1'b0; bresp = 2'b00; creq.valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        creq = '0;
        arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = 0; rid = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 64'({arvalid, awvalid, wvalid, rready, bready, cresp.ready, cresp.last, bus_err}), 64'd0);
        reset = 1'b0;
        tick();
        check("post_reset_out", 64'({arvalid, awvalid, wvalid, rready, bready, cresp.ready, cresp.last, bus_err}), 64'd0);

        // Single read
        bd[0] = 32'hDEADBEEF; br[0] = 2'b00;
        do_read(32'h1FC0_0000, 4'd0, 3'd2, 2'b01, 0, 0, 0, 1'b0, -1);

        // 16-beat INCR read, arready late, rvalid every other cycle
        fill_rand(1'b0);
        do_read(32'h8000_0040, 4'd15, 3'd2, 2'b01, 1, 1, 3, 1'b0, -1);

        // 4-beat write with a stall on beat 2 and late B
        for (int i = 0; i < 4; i++) begin bd[i] = 32'(i + 1); bs[i] = 4'hF; end
        do_write(32'h0000_1000, 4'd3, 3'd2, 2'b01, 1, 1, 3, 0, 5, 2'b00, 1'b0);

        // SLVERR on a single write, then a normal read
        fill_rand(1'b0);
        do_write(32'h0000_2000, 4'd0, 3'd2, 2'b01, 0, -1, 0, 0, 2, 2'b10, 1'b0);
        fill_rand(1'b0);
        do_read(32'h0000_3000, 4'd1, 3'd2, 2'b01, 0, 1, 0, 1'b0, -1);

        // Reset during beat 3 of 8, then fresh read and write
        fill_rand(1'b0);
        do_read(32'h0000_4000, 4'd7, 3'd2, 2'b01, 0, 1, 1, 1'b0, 2);
        fill_rand(1'b0);
        do_read(32'h0000_5000, 4'd3, 3'd2, 2'b00, 0, 1, 0, 1'b0, -1);
        fill_rand(1'b0);
        do_write(32'h0000_6000, 4'd3, 3'd1, 2'b01, 0, -1, 0, 1, 0, 2'b00, 1'b0);

        // Back-to-back read then write
        fill_rand(1'b0);
        do_read(32'h0000_7000, 4'd2, 3'd2, 2'b01, 0, 0, 0, 1'b0, -1);
        fill_rand(1'b0);
        do_write(32'h0000_8000, 4'd1, 3'd2, 2'b01, 0, -1, 0, 0, 0, 2'b00, 1'b1);

        // Randomized mix
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            logic [3:0]  l;
            logic [2:0]  sz;
            logic [1:0]  bu;
            logic [1:0]  be;
            bit          bb;
            fill_rand(1'b1);
            a  = $urandom & 32'hFFFF_FFFC;
            l  = 4'($urandom);
            sz = 3'($urandom_range(2, 0));
            bu = 2'($urandom_range(1, 0));
            be = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            bb = 1'($urandom_range(1, 0));
            if ($urandom_range(1, 0) == 1)
                do_read(a, l, sz, bu, 0, 2, int'($urandom_range(3, 0)), bb, -1);
            else
                do_write(a, l, sz, bu, int'($urandom_range(3, 0)), -1, 0, 2, int'($urandom_range(4, 0)), be, bb);
        end

        tick(); tick();
        check("left_ar", 64'(exp_ar_q.size()), 64'd0);
        check("left_aw", 64'(exp_aw_q.size()), 64'd0);
        check("left_w", 64'(exp_w_q.size()), 64'd0);
        check("left_cresp", 64'(exp_c_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
